// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier arbiter.
// Widths, requester tag type and arbitration mode enum.
package mul_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PROD_W_DEF = 2 * DATA_W_DEF;
  localparam int SCALE_W    = 8;
  localparam int MAX_REQ    = 8;
  localparam int TAG_W      = $clog2(MAX_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } prio_mode_e;

endpackage

// File: rtl/fp_mul_pipe.sv
// Two-stage signed fixed-point multiply pipeline.
// Stage 1 registers the full product; stage 2 shifts and saturates.
module fp_mul_pipe
  import mul_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic [DATA_W-1:0]  i_x,
  input  logic [DATA_W-1:0]  i_y,
  input  logic [SCALE_W-1:0] i_scale,
  input  tag_t               i_tag,
  output logic               o_ovf_set,
  output tag_t               o_ovf_tag,
  output logic               o_valid,
  output tag_t               o_tag,
  output logic [DATA_W-1:0]  o_data
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [DATA_W-1:0]  w_x;
  logic signed [DATA_W-1:0]  w_y;
  logic signed [PROD_W-1:0]  w_prod;

  logic                      r_s1_valid;
  logic signed [PROD_W-1:0]  r_s1_prod;
  logic [SCALE_W-1:0]        r_s1_scale;
  tag_t                      r_s1_tag;

  logic signed [PROD_W-1:0]  w_shift;
  logic [PROD_W-DATA_W:0]    w_hi;
  logic                      w_big;
  logic                      w_ovf;
  logic [DATA_W-1:0]         w_sat;

  logic                      r_s2_valid;
  tag_t                      r_s2_tag;
  logic [DATA_W-1:0]         r_s2_data;

  assign w_x    = i_x;
  assign w_y    = i_y;
  assign w_prod = PROD_W'(w_x) * PROD_W'(w_y);

  // Stage 1: capture full-width product with its scale and tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_scale <= '0;
      r_s1_tag   <= '0;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_prod  <= w_prod;
      r_s1_scale <= i_scale;
      r_s1_tag   <= i_tag;
    end
  end

  // Shift by scale (huge shifts collapse to sign) and saturate
  always_comb begin
    w_big = r_s1_scale >= SCALE_W'(PROD_W - 1);
    if (w_big) begin
      w_shift = {PROD_W{r_s1_prod[PROD_W-1]}};
    end else begin
      w_shift = r_s1_prod >>> r_s1_scale;
    end
    w_hi  = w_shift[PROD_W-1:DATA_W-1];
    w_ovf = ~((&w_hi) | ~(|w_hi));
    w_sat = w_shift[DATA_W-1:0];
    if (w_ovf) begin
      if (w_shift[PROD_W-1]) begin
        w_sat = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        w_sat = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end
  end

  // Stage 2: result register, data forced to zero when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_data  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_tag   <= r_s1_tag;
      r_s2_data  <= r_s1_valid ? w_sat : '0;
    end
  end

  assign o_ovf_set = r_s1_valid & w_ovf;
  assign o_ovf_tag = r_s1_tag;
  assign o_valid   = r_s2_valid;
  assign o_tag     = r_s2_tag;
  assign o_data    = r_s2_data;

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates NUM_REQ requesters onto one multiply pipeline.
// Holds grant logic, round-robin pointer, tag routing and ovf flags.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  input  logic [NUM_REQ*8-1:0]      req_scale,
  input  logic                      prio_mode,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        ovf_flag,
  input  logic [NUM_REQ-1:0]        ovf_clr
);

  tag_t                 r_ptr;
  logic [NUM_REQ-1:0]   r_ovf;

  logic                 w_hit;
  tag_t                 w_gidx;
  tag_t                 w_cand;
  logic [NUM_REQ-1:0]   w_grant;
  logic [DATA_W-1:0]    w_x;
  logic [DATA_W-1:0]    w_y;
  logic [SCALE_W-1:0]   w_scale;

  logic                 w_ovf_set;
  tag_t                 w_ovf_tag;
  logic [NUM_REQ-1:0]   w_ovf_vec;
  logic                 w_p_valid;
  tag_t                 w_p_tag;

  // Pick one valid requester: lowest index or first after pointer
  always_comb begin
    w_hit  = 1'b0;
    w_gidx = '0;
    w_cand = '0;
    if (prio_mode_e'(prio_mode) == ARB_FIXED) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_hit && req_valid[k]) begin
          w_hit  = 1'b1;
          w_gidx = tag_t'(k);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_cand = tag_t'((int'(r_ptr) + k) % NUM_REQ);
        if (!w_hit && req_valid[w_cand]) begin
          w_hit  = 1'b1;
          w_gidx = w_cand;
        end
      end
    end
    w_hit   = w_hit & rst_n;
    w_grant = w_hit ? (NUM_REQ'(1) << w_gidx) : '0;
  end

  assign req_ready = w_grant;

  assign w_x     = req_x[int'(w_gidx)*DATA_W +: DATA_W];
  assign w_y     = req_y[int'(w_gidx)*DATA_W +: DATA_W];
  assign w_scale = req_scale[int'(w_gidx)*8 +: 8];

  // Pointer follows every transfer in either mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= tag_t'(NUM_REQ - 1);
    end else if (w_hit) begin
      r_ptr <= w_gidx;
    end
  end

  fp_mul_pipe #(
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (w_hit),
    .i_x       (w_x),
    .i_y       (w_y),
    .i_scale   (w_scale),
    .i_tag     (w_gidx),
    .o_ovf_set (w_ovf_set),
    .o_ovf_tag (w_ovf_tag),
    .o_valid   (w_p_valid),
    .o_tag     (w_p_tag),
    .o_data    (rsp_data)
  );

  assign w_ovf_vec = w_ovf_set ? (NUM_REQ'(1) << w_ovf_tag) : '0;

  // Sticky overflow flags; a new overflow beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~ovf_clr) | w_ovf_vec;
    end
  end

  assign ovf_flag  = r_ovf;
  assign rsp_valid = w_p_valid ? (NUM_REQ'(1) << w_p_tag) : '0;

endmodule
